mux4_rr_arbiter: RTL and testbench
==================================

MUX4_RR_ARBITER -- requirements
Module: mux4_rr_arbiter

Interface
REQ-001 SHALL have parameter DW, default 4, meaning the per-requester data width.
REQ-002 SHALL have port clk, input, 1, meaning the single clock; all state changes on the rising edge.
REQ-003 SHALL have port rst_n, input, 1, meaning the asynchronous active-low reset.
REQ-004 SHALL have port req, input, 4, meaning per-requester request; bit i belongs to requester i.
REQ-005 SHALL have ports in_a, in_b, in_c, in_d, input, DW each, meaning data for requesters 0..3.
REQ-006 SHALL have port gnt, output, 4, meaning a one-hot, one-cycle pulse marking the requester whose data was captured.
REQ-007 SHALL have port out_valid, output, 1, meaning out_data holds an unconsumed beat.
REQ-008 SHALL have port out_ready, input, 1, meaning the consumer accepts the beat this cycle.
REQ-009 SHALL have ports out_data, output, DW, meaning the captured data, and out_sel, output, 2, meaning the index of its source.

Function
REQ-010 SHALL implement FSM states IDLE (out_valid=0) and HOLD (out_valid=1).
REQ-011 SHALL define load = |req && (state==IDLE || out_ready).
REQ-012 On load, SHALL choose the winner as the first set req bit in the order last+1, last+2, last+3, last (mod 4).
REQ-013 On load, SHALL register out_data from the winner's input, out_sel=winner, out_valid=1, gnt=onehot(winner), last=winner, and enter HOLD.
REQ-014 SHALL give one-cycle latency: req sampled high in cycle N yields gnt and out_valid in cycle N+1.
REQ-015 In HOLD with out_ready=0, SHALL keep out_data, out_sel and out_valid stable and keep gnt=0.
REQ-016 In HOLD with out_ready=1 and no req, SHALL go to IDLE with out_valid=0 and leave out_data unchanged.
REQ-017 In HOLD with out_ready=1 and any req (simultaneous consume and request), SHALL load the next winner in the same cycle, giving one beat per cycle.
REQ-018 SHALL drive gnt=0 in every cycle without a load, and SHALL never assert more than one gnt bit.
REQ-019 SHALL leave requester behaviour to the requester: it holds req and data until its gnt pulse, and a req still high after gnt is a new request.
REQ-020 SHALL ignore an idle out_ready (IDLE, out_ready=1) without side effect.

Reset
REQ-021 While rst_n=0, SHALL force state=IDLE, out_valid=0, gnt=0, out_data=0, out_sel=0, last=3 (requester 0 wins first).
REQ-022 Reset asserted mid-HOLD SHALL drop the pending beat and emit no gnt.
REQ-023 Reset SHALL release synchronously to clk: the first load can occur on the first rising edge with rst_n=1.

Configuration
REQ-024 Macro MUX4_RR_ARBITER_LOCK_EN SHALL control the lock feature.
REQ-025 With MUX4_RR_ARBITER_LOCK_EN defined, SHALL add input lock (4 bits) and register lock[winner] at each load.
REQ-026 With MUX4_RR_ARBITER_LOCK_EN defined, while the locked flag is set and req[last]=1, SHALL give the next load to last regardless of rotation.
REQ-027 With MUX4_RR_ARBITER_LOCK_EN defined, SHALL clear the locked flag at a load with lock[winner]=0, when req[last]=0, or on reset.
REQ-028 Without MUX4_RR_ARBITER_LOCK_EN, SHALL have no lock port and use pure round-robin.

Structure
REQ-029 SHALL place the following in shared package mux4_arb_pkg: the FSM state typedef, the requester-count constant NREQ=4, and a function mapping an index to a one-hot value.
REQ-030 SHALL instantiate sub-module mux4_sel_path, a combinational 4:1 DW-wide selector driven by the winner index, feeding the out_data register.

Verification
REQ-031 Single request: req=0100, in_c=0xA, out_ready=1 -> next cycle gnt=0100, out_valid=1, out_data=0xA, out_sel=2.
REQ-032 Rotation: req=1111 held, out_ready=1, no lock -> successive winners 0,1,2,3,0 with gnt 0001,0010,0100,1000,0001, one beat per cycle.
REQ-033 Backpressure: beat from requester 1 pending, out_ready=0 for 3 cycles, req=1001 -> out_data stable, gnt=0; first out_ready=1 cycle loads requester 3 (last=1).
REQ-034 Reset mid-HOLD: out_valid=1, pull rst_n low -> out_valid=0, gnt=0, out_sel=0 immediately; after release with req=1000, winner=3.
REQ-035 Lock (macro defined): req=0011, lock=0001 -> requester 0 wins repeatedly; drop lock -> next winner 1.
REQ-036 Drain: single beat, out_ready=1, req=0000 -> IDLE, out_valid=0, out_data retains its last value.

Source files
------------

// File: rtl/mux4_arb_pkg.sv
// Shared definitions for the 4-way round-robin capture arbiter.
// Used by mux4_rr_arbiter and mux4_sel_path.
package mux4_arb_pkg;

   localparam int unsigned NREQ = 4;

   typedef enum logic {
      StIdle,
      StHold
   } state_e;

   // Map a requester index to its one-hot grant vector.
   function automatic logic [NREQ-1:0] idx_to_onehot(input logic [1:0] idx);
      return 4'b0001 << idx;
   endfunction

endpackage

// File: rtl/mux4_sel_path.sv
// Combinational 4:1 data selector, steered by the winner index.
module mux4_sel_path #(
   parameter int unsigned DW = 4
) (
   input  logic [1:0]    i_sel,
   input  logic [DW-1:0] i_a,
   input  logic [DW-1:0] i_b,
   input  logic [DW-1:0] i_c,
   input  logic [DW-1:0] i_d,
   output logic [DW-1:0] o_data
);

   // Pick the data word of the selected requester.
   always_comb begin
      o_data = i_a;
      unique case (i_sel)
         2'd0:    o_data = i_a;
         2'd1:    o_data = i_b;
         2'd2:    o_data = i_c;
         default: o_data = i_d;
      endcase
   end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// 4-requester round-robin arbiter capturing the winner's data into a
// single-entry valid/ready output register, one beat per cycle.
// Optional feature: define MUX4_RR_ARBITER_LOCK_EN to add the 'lock' input,
// which lets the last winner keep the grant while it keeps requesting.
module mux4_rr_arbiter
   import mux4_arb_pkg::*;
#(
   parameter int unsigned DW = 4
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [3:0]      req,
   input  logic [DW-1:0]   in_a,
   input  logic [DW-1:0]   in_b,
   input  logic [DW-1:0]   in_c,
   input  logic [DW-1:0]   in_d,
`ifdef MUX4_RR_ARBITER_LOCK_EN
   input  logic [3:0]      lock,
`endif
   output logic [3:0]      gnt,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [DW-1:0]   out_data,
   output logic [1:0]      out_sel
);

   state_e          r_state;
   state_e          w_state_nxt;
   logic [1:0]      r_last;
   logic [1:0]      r_sel;
   logic [DW-1:0]   r_data;
   logic [3:0]      r_gnt;
   logic            w_load;
   logic [1:0]      w_rr_winner;
   logic [1:0]      w_winner;
   logic [DW-1:0]   w_sel_data;

   assign w_load = (|req) && ((r_state == StIdle) || out_ready);

   // Rotating priority search: offset 1 is highest, offset 0 (last) lowest.
   always_comb begin
      w_rr_winner = r_last;
      for (int k = 3; k >= 1; k--) begin
         if (req[r_last + 2'(k)]) begin
            w_rr_winner = r_last + 2'(k);
         end
      end
   end

`ifdef MUX4_RR_ARBITER_LOCK_EN
   logic r_locked;

   // A locked last winner that still requests overrides the rotation.
   always_comb begin
      w_winner = w_rr_winner;
      if (r_locked && req[r_last]) begin
         w_winner = r_last;
      end
   end

   // Lock flag follows lock[winner] at each load; drops once the holder lets go.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_locked <= 1'b0;
      end else if (w_load) begin
         r_locked <= lock[w_winner];
      end else if (!req[r_last]) begin
         r_locked <= 1'b0;
      end
   end
`else
   // Pure round-robin.
   always_comb begin
      w_winner = w_rr_winner;
   end
`endif

   mux4_sel_path #(
      .DW (DW)
   ) u_sel_path (
      .i_sel  (w_winner),
      .i_a    (in_a),
      .i_b    (in_b),
      .i_c    (in_c),
      .i_d    (in_d),
      .o_data (w_sel_data)
   );

   // FSM state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= StIdle;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // FSM next state: a load always lands in HOLD; a consumed beat with no load idles.
   always_comb begin
      w_state_nxt = r_state;
      if (w_load) begin
         w_state_nxt = StHold;
      end else if ((r_state == StHold) && out_ready) begin
         w_state_nxt = StIdle;
      end
   end

   // Capture the winner's beat and pulse its grant for one cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_data <= '0;
         r_sel  <= 2'd0;
         r_last <= 2'd3;
         r_gnt  <= 4'b0000;
      end else begin
         r_gnt <= 4'b0000;
         if (w_load) begin
            r_data <= w_sel_data;
            r_sel  <= w_winner;
            r_last <= w_winner;
            r_gnt  <= idx_to_onehot(w_winner);
         end
      end
   end

   assign gnt       = r_gnt;
   assign out_valid = (r_state == StHold);
   assign out_data  = r_data;
   assign out_sel   = r_sel;

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Directed self-checking bench for mux4_rr_arbiter.
// The lock scenario is compiled in only with MUX4_RR_ARBITER_LOCK_EN.
module tb_mux4_rr_arbiter;

   localparam int unsigned DW = 4;

   logic          clk;
   logic          rst_n;
   logic [3:0]    req;
   logic [DW-1:0] in_a, in_b, in_c, in_d;
`ifdef MUX4_RR_ARBITER_LOCK_EN
   logic [3:0]    lock;
`endif
   logic [3:0]    gnt;
   logic          out_valid;
   logic          out_ready;
   logic [DW-1:0] out_data;
   logic [1:0]    out_sel;

   int n_checks = 0;
   int n_fail   = 0;

   mux4_rr_arbiter #(
      .DW (DW)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req       (req),
      .in_a      (in_a),
      .in_b      (in_b),
      .in_c      (in_c),
      .in_d      (in_d),
`ifdef MUX4_RR_ARBITER_LOCK_EN
      .lock      (lock),
`endif
      .gnt       (gnt),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_sel   (out_sel)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Advance to just after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Check one captured beat.
   task automatic check_beat(input string tag, input logic [3:0] g, input logic [1:0] s,
                             input logic [DW-1:0] d);
      check({tag, ".gnt"},   32'(gnt),       32'(g));
      check({tag, ".valid"}, 32'(out_valid), 32'd1);
      check({tag, ".sel"},   32'(out_sel),   32'(s));
      check({tag, ".data"},  32'(out_data),  32'(d));
   endtask

   initial begin
      rst_n     = 1'b0;
      req       = 4'b0000;
      out_ready = 1'b0;
      in_a      = 4'h5;
      in_b      = 4'h6;
      in_c      = 4'hA;
      in_d      = 4'h9;
`ifdef MUX4_RR_ARBITER_LOCK_EN
      lock      = 4'b0000;
`endif
      tick();
      tick();
      check("rst.valid", 32'(out_valid), 32'd0);
      check("rst.gnt",   32'(gnt),       32'd0);
      check("rst.data",  32'(out_data),  32'd0);
      check("rst.sel",   32'(out_sel),   32'd0);

      // Single request from requester 2; one-cycle latency after release.
      rst_n     = 1'b1;
      req       = 4'b0100;
      out_ready = 1'b1;
      tick();
      check_beat("single", 4'b0100, 2'd2, 4'hA);

      // Drain: beat consumed, no request -> idle, data retained.
      req = 4'b0000;
      tick();
      check("drain.valid", 32'(out_valid), 32'd0);
      check("drain.gnt",   32'(gnt),       32'd0);
      check("drain.data",  32'(out_data),  32'hA);

      // last=2 -> requester 3 wins, leaving last=3 for the rotation run.
      req = 4'b1000;
      tick();
      check_beat("pre_rot", 4'b1000, 2'd3, 4'h9);

      // Rotation with all requesting and ready high: 0,1,2,3,0.
      req = 4'b1111;
      tick(); check_beat("rot0", 4'b0001, 2'd0, 4'h5);
      tick(); check_beat("rot1", 4'b0010, 2'd1, 4'h6);
      tick(); check_beat("rot2", 4'b0100, 2'd2, 4'hA);
      tick(); check_beat("rot3", 4'b1000, 2'd3, 4'h9);
      tick(); check_beat("rot4", 4'b0001, 2'd0, 4'h5);

      // Backpressure: requester 1 beat pending, stall 3 cycles with req=1001.
      req = 4'b0010;
      tick();
      check_beat("bp_load", 4'b0010, 2'd1, 4'h6);
      req       = 4'b1001;
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         check_beat($sformatf("bp_stall%0d", i), 4'b0000, 2'd1, 4'h6);
      end
      out_ready = 1'b1;
      tick();
      check_beat("bp_release", 4'b1000, 2'd3, 4'h9);

      // Idle out_ready with no request has no effect.
      req = 4'b0000;
      tick();
      tick();
      check("idle_rdy.valid", 32'(out_valid), 32'd0);
      check("idle_rdy.gnt",   32'(gnt),       32'd0);
      check("idle_rdy.data",  32'(out_data),  32'h9);
      check("idle_rdy.sel",   32'(out_sel),   32'd3);

      // Reset mid-HOLD drops the beat asynchronously.
      req = 4'b0100;
      tick();
      check_beat("pre_rst", 4'b0100, 2'd2, 4'hA);
      req       = 4'b0000;
      out_ready = 1'b0;
      tick();
      #2;
      rst_n = 1'b0;
      #1;
      check("mid_rst.valid", 32'(out_valid), 32'd0);
      check("mid_rst.gnt",   32'(gnt),       32'd0);
      check("mid_rst.sel",   32'(out_sel),   32'd0);
      tick();
      rst_n     = 1'b1;
      req       = 4'b1000;
      out_ready = 1'b1;
      tick();
      check_beat("post_rst", 4'b1000, 2'd3, 4'h9);

`ifdef MUX4_RR_ARBITER_LOCK_EN
      // Lock: requester 0 keeps winning; after lock drops the flag clears at
      // the next load (still won by 0), then rotation resumes with 1.
      req  = 4'b0011;
      lock = 4'b0001;
      for (int i = 0; i < 3; i++) begin
         tick();
         check_beat($sformatf("lock%0d", i), 4'b0001, 2'd0, 4'h5);
      end
      lock = 4'b0000;
      tick();
      check_beat("unlock0", 4'b0001, 2'd0, 4'h5);
      tick();
      check_beat("unlock1", 4'b0010, 2'd1, 4'h6);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
